// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path.
//
// Contents:
//   - branch-condition codes (3 bits) used by the execute and fetch stages
//   - bit positions of the {S,Z,C,V} flags inside szcv / ccr vectors
//   - encodings of the writeback FIFO occupancy state machine
package alu_pkg;

   // Branch-condition codes as carried on br_cond. Codes 100..110 are reserved
   // and always evaluate to not-taken.
   localparam logic [2:0] COND_BE  = 3'b000;  // Z
   localparam logic [2:0] COND_BLT = 3'b001;  // S ^ V
   localparam logic [2:0] COND_BLE = 3'b010;  // Z | (S ^ V)
   localparam logic [2:0] COND_BNE = 3'b011;  // !Z
   localparam logic [2:0] COND_B   = 3'b111;  // always

   // Flag positions inside a 4-bit {S,Z,C,V} vector.
   localparam int unsigned FLAG_S = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   localparam int unsigned FLAGS_W = 4;

   // Writeback FIFO occupancy; the encoding equals the entry count.
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } fifo_state_e;

   // Replace masked CCR bits with freshly supplied flags.
   function automatic logic [FLAGS_W-1:0] merge_flags(
      input logic [FLAGS_W-1:0] old_flags,
      input logic [FLAGS_W-1:0] new_flags,
      input logic [FLAGS_W-1:0] mask
   );
      return (old_flags & ~mask) | (new_flags & mask);
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator.
//
// Decodes a 3-bit condition code against an {S,Z,C,V} flag vector. Shared by
// the result-commit block (forwarded CCR) and the fetch-stage predictor check.
//
// Ports:
//   cond     in  3  branch-condition code
//   ccr_eff  in  4  flags {S,Z,C,V} the condition is evaluated against
//   taken    out 1  condition holds
module branch_cond_eval
   import alu_pkg::*;
(
   input  logic [2:0]         cond,
   input  logic [FLAGS_W-1:0] ccr_eff,
   output logic               taken
);

   logic flag_s;
   logic flag_z;
   logic flag_v;
   logic lt;
   // No condition in the set looks at carry.
   logic unused_flag_c;

   assign flag_s        = ccr_eff[FLAG_S];
   assign flag_z        = ccr_eff[FLAG_Z];
   assign flag_v        = ccr_eff[FLAG_V];
   assign unused_flag_c = ccr_eff[FLAG_C];

   // Signed less-than after a compare.
   assign lt = flag_s ^ flag_v;

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_BE:  taken = flag_z;
         COND_BLT: taken = lt;
         COND_BLE: taken = flag_z | lt;
         COND_BNE: taken = ~flag_z;
         COND_B:   taken = 1'b1;
         default:  taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_result_commit.sv
// Consumer end of the ALU/shifter result interface.
//
// Accepts a result, its {S,Z,C,V} flags and a destination register through a
// valid/ready handshake. Masked flags are committed into the condition-code
// register, branch conditions are evaluated every cycle against the CCR with
// same-cycle forwarding, and register-file writebacks are buffered in a
// 2-entry FIFO drained through a second valid/ready handshake.
//
// Ports:
//   clk           in   1       system clock, rising edge
//   rst           in   1       asynchronous active-high reset
//   in_valid      in   1       execute stage presents a result
//   in_ready      out  1       block can accept this cycle
//   in_res        in   DATA_W  ALU result
//   in_szcv       in   4       flags {S,Z,C,V}
//   in_flag_mask  in   4       per-bit CCR update enable
//   in_wr_en      in   1       result goes to the register file
//   in_rd         in   REG_AW  destination register
//   br_cond       in   3       branch-condition code
//   br_taken      out  1       condition result (combinational)
//   ccr           out  4       current CCR {S,Z,C,V}
//   wb_valid      out  1       FIFO head valid
//   wb_ready      in   1       register file takes the head
//   wb_data       out  DATA_W  head data
//   wb_addr       out  REG_AW  head destination
module alu_result_commit
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 3,
   // Only 2 is supported: the pointers are single bits.
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_res,
   input  logic [3:0]        in_szcv,
   input  logic [3:0]        in_flag_mask,
   input  logic              in_wr_en,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [2:0]        br_cond,
   output logic              br_taken,
   output logic [3:0]        ccr,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [DATA_W-1:0] wb_data,
   output logic [REG_AW-1:0] wb_addr
);

   // ---------------------------------------------------------------------
   // Handshake events
   // ---------------------------------------------------------------------
   logic accept;
   logic push;
   logic pop;

   assign accept = in_valid & in_ready;
   assign push   = accept & in_wr_en;
   assign pop    = wb_valid & wb_ready;

   // ---------------------------------------------------------------------
   // Condition-code register with forwarding
   // ---------------------------------------------------------------------
   logic [FLAGS_W-1:0] ccr_q;
   logic [FLAGS_W-1:0] ccr_eff;

   // The forwarded view is exactly what the CCR will hold after this edge,
   // so it doubles as the next-state value.
   always_comb begin
      ccr_eff = ccr_q;
      if (accept) begin
         ccr_eff = merge_flags(ccr_q, in_szcv, in_flag_mask);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ccr_q <= '0;
      end else begin
         ccr_q <= ccr_eff;
      end
   end

   assign ccr = ccr_q;

   branch_cond_eval u_branch_cond_eval (
      .cond    (br_cond),
      .ccr_eff (ccr_eff),
      .taken   (br_taken)
   );

   // ---------------------------------------------------------------------
   // Writeback FIFO occupancy state machine
   // ---------------------------------------------------------------------
   fifo_state_e state_q;
   fifo_state_e state_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StEmpty: begin
            // wb_valid is low here, so pop cannot occur.
            if (push) begin
               state_d = StOne;
            end
         end
         StOne: begin
            if (push && !pop) begin
               state_d = StFull;
            end else if (!push && pop) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            // in_ready is low here, so push cannot occur.
            if (pop) begin
               state_d = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   // Both flow-control outputs come from registered state only; a pop in
   // StFull frees space for the following cycle, not the current one.
   always_comb begin
      in_ready = 1'b1;
      wb_valid = 1'b0;
      unique case (state_q)
         StEmpty: begin
            in_ready = 1'b1;
            wb_valid = 1'b0;
         end
         StOne: begin
            in_ready = 1'b1;
            wb_valid = 1'b1;
         end
         StFull: begin
            in_ready = 1'b0;
            wb_valid = 1'b1;
         end
         default: begin
            in_ready = 1'b1;
            wb_valid = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // FIFO storage and pointers
   // ---------------------------------------------------------------------
   logic [DATA_W-1:0] mem_data_q [DEPTH];
   logic [REG_AW-1:0] mem_addr_q [DEPTH];
   logic              wr_ptr_q;
   logic              rd_ptr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_data_q[i] <= '0;
            mem_addr_q[i] <= '0;
         end
      end else if (push) begin
         mem_data_q[wr_ptr_q] <= in_res;
         mem_addr_q[wr_ptr_q] <= in_rd;
      end
   end

   // Head is forced to zero while empty so stale entries never show.
   always_comb begin
      wb_data = '0;
      wb_addr = '0;
      if (wb_valid) begin
         wb_data = mem_data_q[rd_ptr_q];
         wb_addr = mem_addr_q[rd_ptr_q];
      end
   end

endmodule

// File: doc/alu_result_commit.md
Name: alu_result_commit

Overview:
- Consumer end of the ALU/shifter result interface.
- Accepts each ALU result, its szcv flags and its destination register through a valid/ready handshake.
- Commits flags into the condition-code register (CCR), evaluates branch conditions against the CCR, and buffers register-file writebacks in a 2-entry FIFO.
- Sits between the execute stage and the register-file write port.

Parameters:
- DATA_W, 16, result width (ALU datapath width).
- REG_AW, 3, register-address width (8 GPRs).
- DEPTH, 2, writeback FIFO depth; only the value 2 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  execute stage presents a result.
- in_ready  out  1  block can accept this cycle.
- in_res  in  DATA_W  ALU result.
- in_szcv  in  4  flags {S,Z,C,V}, same bit order as the ALU.
- in_flag_mask  in  4  per-bit CCR update enable; a 0 bit leaves that CCR bit unchanged.
- in_wr_en  in  1  result is to be written to the register file.
- in_rd  in  REG_AW  destination register.
- br_cond  in  3  branch-condition code, evaluated every cycle.
- br_taken  out  1  condition result, combinational.
- ccr  out  4  current CCR contents {S,Z,C,V}.
- wb_valid  out  1  FIFO head is valid.
- wb_ready  in  1  register file takes the head.
- wb_data  out  DATA_W  head data.
- wb_addr  out  REG_AW  head destination.

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO emptied; count=0; read and write pointers=0.
  - ccr=4'b0000, wb_valid=0, wb_data=0, wb_addr=0.
  - in_ready=1 from the first cycle after rst deasserts.
  - rst asserted mid-operation discards all buffered writebacks and the CCR; there is no partial drain.
- Accept: the accept event is in_valid & in_ready at a rising clk edge.
- CCR update on accept: each CCR bit i with in_flag_mask[i]=1 takes in_szcv[i] at that edge. The CCR is visible on ccr the next cycle.
- Enqueue on accept: happens only if in_wr_en=1. A flag-only accept (in_wr_en=0) never needs FIFO space but still obeys in_ready.
- FIFO state machine, states EMPTY(0), ONE(1), FULL(2):
  - push = accept & in_wr_en; pop = wb_valid & wb_ready.
  - EMPTY: push -> ONE. Pop is impossible because wb_valid=0.
  - ONE: push & pop -> ONE (head replaced by the new entry next cycle); push only -> FULL; pop only -> EMPTY.
  - FULL: pop -> ONE. Push is impossible because in_ready=0.
- in_ready = (state != FULL). It is registered-state-derived, with no combinational path from wb_ready. A pop in FULL therefore does not permit a same-cycle accept.
- wb_valid = (state != EMPTY). wb_data and wb_addr show the head entry; they hold stable while wb_valid & !wb_ready.
- Latency:
  - Accepted result appears on wb_* one cycle after the accept edge when the FIFO was empty, i.e. a 1-cycle minimum latency.
  - Writebacks leave in order.
- Pointers are 1 bit wide and wrap 1->0.
- Branch evaluation (S=ccr_eff[3], Z=ccr_eff[2], V=ccr_eff[0]):
  - 000 BE -> Z.
  - 001 BLT -> S^V.
  - 010 BLE -> Z | (S^V).
  - 011 BNE -> !Z.
  - 111 B -> 1.
  - 100, 101, 110 -> 0.
- Flag forwarding: ccr_eff is the CCR with masked bits replaced by in_szcv when in_valid & in_ready in the current cycle. A branch in the same cycle as a flag-setting CMP therefore sees the new flags.
- C is stored as supplied; the ALU drives it 0.
- Callers mask out V for non-ADD/SUB ops. V is never sampled unmasked from those ops.

Decomposition:
- Shared package (alu_pkg) holds:
  - Branch-condition localparams COND_BE/BLT/BLE/BNE/B.
  - szcv bit indices FLAG_S=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FIFO state encodings.
- One sub-module, branch_cond_eval: combinational {cond, ccr_eff} -> taken, reused by the fetch-stage predictor check.
- FIFO storage and the CCR stay inline.

Test Plan:
- Reset mid-traffic: rst pulse with FIFO FULL -> same cycle wb_valid=0, ccr=0000; after release in_ready=1.
- Push then drain: accept res=16'h1234, rd=3, wr_en=1 with wb_ready=0 -> next cycle wb_valid=1, wb_data=1234, wb_addr=3; data holds until wb_ready=1, then wb_valid=0.
- Back-pressure: three accepts with wb_ready=0 -> third blocked, in_ready=0 after second; one pop -> in_ready=1; order 1st,2nd,3rd preserved on wb_data.
- Simultaneous push/pop in ONE: head A, push B with wb_ready=1 -> next cycle state ONE, wb_data=B.
- Flag forwarding: CMP accept szcv=0100, mask=1111, wr_en=0, br_cond=000 same cycle -> br_taken=1; next cycle ccr=0100; no FIFO entry created.
- Masked update and BLT: ccr=0000, accept szcv=1001 mask=0100 -> ccr stays 0000; accept szcv=1000 mask=1001 -> ccr=1000, br_cond=001 -> br_taken=1, br_cond=010 -> 1, br_cond=101 -> 0.
